// File: rtl/t02_bus_arbiter.sv
// N-channel memory-bus manager: arbitrates requesters onto one busy-handshake bus.
// Optional build macro ARB_TIMEOUT_EN adds an 8-bit transaction timeout that completes with rsp_err.
module t02_bus_arbiter #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned FIXED_PRIO  = 0,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  input  logic [NUM_CH*SEL_W-1:0]  req_sel,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic [NUM_CH-1:0]        grant,
  output logic [ADDR_W-1:0]        adr_o,
  output logic [DATA_W-1:0]        dat_o,
  output logic [SEL_W-1:0]         sel_o,
  output logic                     read_o,
  output logic                     write_o,
  input  logic [DATA_W-1:0]        dat_i,
  input  logic                     busy_i
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYC > 255 || SEL_W * 8 != DATA_W) begin : gen_param_check
    $error("t02_bus_arbiter: unsupported parameter combination");
  end

  logic [1:0]        state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]  gidx_q, gidx_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              tmo_hit;

  // Winner search: upward from the round-robin pointer, or from ch0 in fixed-priority mode
  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  win_idx;
  logic              found;

  always_comb begin
    cand    = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (FIXED_PRIO != 0) begin
        cand = PTR_W'(i);
      end else begin
        cand = PTR_W'((32'(ptr_q) + i) % NUM_CH);
      end
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TmoLimit = 8'(TIMEOUT_CYC);
  logic [7:0] tmo_q, tmo_d;
  logic       rsp_err_q, rsp_err_d;

  assign tmo_hit = (tmo_q == TmoLimit);

  // Held at zero while idle, so it is clear on every entry to ISSUE
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == StIdle) begin
      tmo_d = '0;
    end else if (state_q == StIssue || state_q == StWait) begin
      tmo_d = tmo_q + 8'd1;
    end
  end

  assign rsp_err_d = tmo_hit && (state_q == StIssue || state_q == StWait);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    read_d      = read_q;
    write_d     = write_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StIssue;
          grant_d = NUM_CH'(1) << win_idx;
          gidx_d  = win_idx;
          adr_d   = req_addr[win_idx * ADDR_W +: ADDR_W];
          dat_d   = req_wdata[win_idx * DATA_W +: DATA_W];
          sel_d   = req_sel[win_idx * SEL_W +: SEL_W];
          read_d  = ~req_write[win_idx];
          write_d = req_write[win_idx];
        end
      end
      StIssue, StWait: begin
        if (tmo_hit) begin
          read_d      = 1'b0;
          write_d     = 1'b0;
          rsp_rdata_d = '0;
          rsp_valid_d = grant_q;
          state_d     = StDone;
        end else if (state_q == StIssue) begin
          // Any busy seen here, even one left over from before, acknowledges the strobe
          if (busy_i) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            state_d = StWait;
          end
        end else if (!busy_i) begin
          rsp_rdata_d = dat_i;
          rsp_valid_d = grant_q;
          state_d     = StDone;
        end
      end
      StDone: begin
        grant_d = '0;
        ptr_d   = (32'(gidx_q) == NUM_CH - 1) ? '0 : gidx_q + PTR_W'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      read_q      <= read_d;
      write_q     <= write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign grant     = grant_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign sel_o     = sel_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_t02_bus_arbiter.sv
// Directed bench for t02_bus_arbiter: round-robin instance plus a fixed-priority twin on the same bus.
module tb_t02_bus_arbiter;

  localparam int unsigned NCH = 3;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NCH-1:0]    req_valid, req_write;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [NCH*SW-1:0] req_sel;
  logic [DW-1:0]     dat_i;
  logic              busy_i;

  logic [NCH-1:0] rsp_valid, grant;
  logic [DW-1:0]  rsp_rdata, dat_o;
  logic           rsp_err, read_o, write_o;
  logic [AW-1:0]  adr_o;
  logic [SW-1:0]  sel_o;

  logic [NCH-1:0] fp_rsp_valid, fp_grant;
  logic [DW-1:0]  fp_rsp_rdata, fp_dat_o;
  logic           fp_rsp_err, fp_read_o, fp_write_o;
  logic [AW-1:0]  fp_adr_o;
  logic [SW-1:0]  fp_sel_o;

  t02_bus_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .FIXED_PRIO(0),
                    .TIMEOUT_CYC(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_sel(req_sel), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .grant(grant), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
    .read_o(read_o), .write_o(write_o), .dat_i(dat_i), .busy_i(busy_i)
  );

  t02_bus_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .FIXED_PRIO(1),
                    .TIMEOUT_CYC(10)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_sel(req_sel), .rsp_valid(fp_rsp_valid),
    .rsp_rdata(fp_rsp_rdata), .rsp_err(fp_rsp_err), .grant(fp_grant), .adr_o(fp_adr_o),
    .dat_o(fp_dat_o), .sel_o(fp_sel_o), .read_o(fp_read_o), .write_o(fp_write_o),
    .dat_i(dat_i), .busy_i(busy_i)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int ch, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_addr[ch*AW +: AW]  = a;
    req_wdata[ch*DW +: DW] = d;
    req_sel[ch*SW +: SW]   = s;
    req_write[ch]          = wr;
    req_valid[ch]          = 1'b1;
  endtask

  // Bus model: busy rises with the strobe, stays high busy_len cycles, then drops with dat_i valid
  int busy_len = 1;
  int bcnt     = 0;
  bit stuck    = 1'b0;

  always @(negedge clk) begin
    if (stuck) begin
      busy_i = 1'b1;
    end else if (read_o | write_o) begin
      busy_i = 1'b1;
      bcnt   = busy_len - 1;
    end else if (bcnt > 0) begin
      bcnt--;
      busy_i = 1'b1;
    end else begin
      busy_i = 1'b0;
    end
  end

  logic [NCH-1:0] rr_seq [4];
  logic [NCH-1:0] fp_seq [4];
  logic [NCH-1:0] seen_vec;
  logic [DW-1:0]  seen_rdata;
  logic           seen_err;
  int             n, seen_at, pulses;

  initial begin
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_sel = '0;
    dat_i = '0; busy_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst grant", grant, 0);
    check_eq("rst rsp_valid", rsp_valid, 0);
    check_eq("rst rsp_rdata", rsp_rdata, 0);
    check_eq("rst rsp_err", rsp_err, 0);
    check_eq("rst adr_o", adr_o, 0);
    check_eq("rst dat_o", dat_o, 0);
    check_eq("rst sel_o", sel_o, 0);
    check_eq("rst read_o", read_o, 0);
    check_eq("rst write_o", write_o, 0);
    rst = 1'b0;

    // ch1 read, two busy cycles
    dat_i = 32'hDEAD_BEEF; busy_len = 2;
    set_req(1, 1'b0, 32'h40, 32'h0, 4'hF);
    @(negedge clk);
    check_eq("t1 c1 read_o", read_o, 1);
    check_eq("t1 c1 write_o", write_o, 0);
    check_eq("t1 c1 adr_o", adr_o, 32'h40);
    check_eq("t1 c1 grant", grant, 3'b010);
    @(negedge clk);
    check_eq("t1 c2 read_o", read_o, 0);
    @(negedge clk);
    check_eq("t1 c3 rsp_valid", rsp_valid, 0);
    @(negedge clk);
    check_eq("t1 c4 rsp_valid", rsp_valid, 3'b010);
    check_eq("t1 c4 rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check_eq("t1 c4 rsp_err", rsp_err, 0);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check_eq("t1 c5 rsp_valid", rsp_valid, 0);
    check_eq("t1 c5 grant", grant, 0);

    // ch0 write; rdata still follows dat_i on completion
    dat_i = 32'hAAAA_5555; busy_len = 1;
    set_req(0, 1'b1, 32'h80, 32'h1234_5678, 4'b0011);
    @(negedge clk);
    check_eq("t2 write_o", write_o, 1);
    check_eq("t2 read_o", read_o, 0);
    check_eq("t2 adr_o", adr_o, 32'h80);
    check_eq("t2 dat_o", dat_o, 32'h1234_5678);
    check_eq("t2 sel_o", sel_o, 4'b0011);
    check_eq("t2 grant", grant, 3'b001);
    @(negedge clk);
    check_eq("t2 c2 write_o", write_o, 0);
    @(negedge clk);
    check_eq("t2 rsp_valid", rsp_valid, 3'b001);
    check_eq("t2 rsp_rdata", rsp_rdata, 32'hAAAA_5555);
    req_valid = '0; req_write = '0;

    // Continuous requests from all channels, pointer reset to 0
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'h200, 32'h0, 4'hF);
    set_req(2, 1'b0, 32'h300, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      rr_seq[k] = '0;
      fp_seq[k] = '0;
    end
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (read_o) begin
        rr_seq[n] = grant;
        fp_seq[n] = fp_grant;
        n++;
      end
    end
    req_valid = '0;
    check_eq("t3 strobes seen", n, 4);
    check_eq("t3 rr grant0", rr_seq[0], 3'b001);
    check_eq("t3 rr grant1", rr_seq[1], 3'b010);
    check_eq("t3 rr grant2", rr_seq[2], 3'b100);
    check_eq("t3 rr grant3", rr_seq[3], 3'b001);
    for (int k = 0; k < 4; k++) check_eq("t3 fp grant", fp_seq[k], 3'b001);
    repeat (6) @(negedge clk);

    // Reset while waiting on a ch2 read; pointer (now 1) must return to 0
    dat_i = 32'h5A5A_5A5A; busy_len = 3;
    set_req(2, 1'b0, 32'h2C0, 32'h0, 4'hF);
    @(negedge clk);
    check_eq("t4 c1 grant", grant, 3'b100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t4 rst grant", grant, 0);
    check_eq("t4 rst read_o", read_o, 0);
    check_eq("t4 rst rsp_valid", rsp_valid, 0);
    check_eq("t4 rst rsp_rdata", rsp_rdata, 0);
    check_eq("t4 rst adr_o", adr_o, 0);
    rst = 1'b0; req_valid = '0; busy_len = 1;
    set_req(0, 1'b0, 32'h10, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'h20, 32'h0, 4'hF);
    @(negedge clk);
    check_eq("t4 new grant", grant, 3'b001);
    check_eq("t4 new read_o", read_o, 1);
    seen_vec = '0;
    for (int i = 0; i < 20 && seen_vec == 0; i++) begin
      @(negedge clk);
      seen_vec = rsp_valid;
    end
    check_eq("t4 rsp_valid", seen_vec, 3'b001);
    req_valid[0] = 1'b0;

    // ch1 (still pending) is granted next and drops its request mid-transaction
    n = 0;
    for (int i = 0; i < 20 && !read_o; i++) @(negedge clk);
    check_eq("t5 grant", grant, 3'b010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    pulses = 0; seen_vec = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid != 0) begin
        pulses++;
        seen_vec = rsp_valid;
      end
    end
    check_eq("t5 rsp pulses", pulses, 1);
    check_eq("t5 rsp_valid", seen_vec, 3'b010);
    check_eq("t5 idle grant", grant, 0);
    check_eq("t5 idle read_o", read_o, 0);

    // busy stuck high (already high in IDLE)
    stuck = 1'b1; dat_i = 32'h0000_0077;
    @(negedge clk);
    set_req(2, 1'b0, 32'h3C0, 32'h0, 4'hF);
    @(negedge clk);
    check_eq("t6 c1 read_o", read_o, 1);
    check_eq("t6 c1 grant", grant, 3'b100);
    @(negedge clk);
    check_eq("t6 c2 read_o", read_o, 0);
    seen_at = 0; seen_vec = '0; seen_err = 1'b0; seen_rdata = '1;
    for (int c = 3; c <= 1000 && seen_at == 0; c++) begin
      @(negedge clk);
      if (rsp_valid != 0) begin
        seen_at    = c;
        seen_vec   = rsp_valid;
        seen_err   = rsp_err;
        seen_rdata = rsp_rdata;
      end
    end
`ifdef ARB_TIMEOUT_EN
    check_eq("t6 timeout cycle", seen_at, 12);
    check_eq("t6 timeout rsp_valid", seen_vec, 3'b100);
    check_eq("t6 timeout rsp_err", seen_err, 1);
    check_eq("t6 timeout rsp_rdata", seen_rdata, 0);
`else
    check_eq("t6 no completion", seen_at, 0);
`endif
    stuck = 1'b0; req_valid = '0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
